alu_p_accumulator: RTL and testbench
====================================

ALU_P_ACCUMULATOR -- requirements
Module: alu_p_accumulator

Interface
REQ-001 Parameter: Width, default 48, ALU datapath width (S, W_FB, P_OUT).
REQ-002 Parameter: LenW, default 8, width of the term-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-005 start  input  1  pulse, begins an accumulation run; sampled only in IDLE.
REQ-006 acc_len  input  LenW  number of terms in the run; latched on accepted start.
REQ-007 in_valid  input  1  ALU result S/COUT is valid this cycle.
REQ-008 in_ready  output  1  block accepts S/COUT this cycle.
REQ-009 S  input  Width  ALU sum output (W+X+Y+CIN).
REQ-010 COUT  input  1  ALU carry-out (bit 0 of the ALU carry vector).
REQ-011 W_FB  output  Width  feedback operand driven to the ALU W port.
REQ-012 P_OUT  output  Width  final accumulated result.
REQ-013 OVF  output  1  sticky carry-out flag for the run, valid with P_OUT.
REQ-014 out_valid  output  1  P_OUT/OVF hold a completed result.
REQ-015 out_ready  input  1  downstream consumes the result.

Function
REQ-016 State machine SHALL have exactly three states: IDLE, ACC, DONE.
REQ-017 IDLE -> ACC on start=1; latch len = (acc_len==0 ? 1 : acc_len); clear cnt, P, ovf_sticky.
REQ-018 start in ACC or DONE SHALL be ignored (no relatch, no state change).
REQ-019 in_ready SHALL be 1 only in ACC; 0 in IDLE and DONE.
REQ-020 Accept = in_valid & in_ready; only accepted cycles update P, cnt, ovf_sticky.
REQ-021 On accept: P <= S; ovf_sticky <= ovf_sticky | COUT; cnt <= cnt+1.
REQ-022 W_FB SHALL be combinational: P in ACC when cnt>0, else all zeros (first term starts from 0).
REQ-023 Accept with cnt+1 == len: P_OUT <= S, OVF <= ovf_sticky | COUT, go DONE; out_valid = 1 on the next cycle (latency 1 cycle after final accept).
REQ-024 cnt SHALL be LenW+1 bits wide; no wrap for len up to 2^LenW-1.
REQ-025 Arithmetic: P is stored unmodified at Width bits; no saturation, no sign extension; overflow is reported only via OVF.
REQ-026 DONE: out_valid = 1; P_OUT and OVF held stable until out_valid & out_ready.
REQ-027 DONE with out_ready=1 -> IDLE next cycle; out_valid drops that cycle; P_OUT/OVF retain last value.
REQ-028 in_valid while in_ready=0 SHALL be ignored with no side effects.
REQ-029 Start accepted in the same cycle as a DONE->IDLE handshake SHALL be ignored (start only sampled while in IDLE).
REQ-030 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031 While reset=1: state=IDLE, P=0, cnt=0, len=0, ovf_sticky=0, P_OUT=0, OVF=0, out_valid=0, in_ready=0, W_FB=0.
REQ-032 Reset asserted mid-run (ACC or DONE) SHALL abort the run; no result is produced; first start after reset release begins a fresh run.

Verification
REQ-033 start, acc_len=3; S=10,20,30 (COUT=0) accepted back-to-back -> W_FB=0,10,20 on accept cycles; one cycle after 3rd accept out_valid=1, P_OUT=30, OVF=0.
REQ-034 acc_len=0, S=0x123 accepted -> treated as len 1; out_valid=1 next cycle with P_OUT=0x123.
REQ-035 acc_len=2, COUT=1 on term 1, 0 on term 2 -> OVF=1 with result; next run with COUT=0 throughout -> OVF=0.
REQ-036 acc_len=2 with in_valid gaps of 3 cycles and out_ready=0 for 5 cycles after completion -> P_OUT/OVF stable, in_ready=0, extra in_valid/start ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset pulsed after 1 of 4 terms -> all outputs 0 immediately; new run acc_len=1, S=7 -> P_OUT=7, OVF=0.
REQ-038 S=0xFFFF_FFFF_FFFF on a run of acc_len=1 -> P_OUT=0xFFFF_FFFF_FFFF (full Width kept, no truncation).

Source files
------------

// File: rtl/alu_p_accumulator_if.sv
// Handshake and data bundle between the ALU-side producer, the P accumulator and the result consumer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the term side, out_valid/out_ready on the result side.
interface alu_p_accumulator_if #(
    parameter int Width = 48,
    parameter int LenW  = 8
);
    logic             start;
    logic [LenW-1:0]  acc_len;
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] S;
    logic             COUT;
    logic [Width-1:0] W_FB;
    logic [Width-1:0] P_OUT;
    logic             OVF;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output start, acc_len, in_valid, S, COUT, out_ready,
        input  in_ready, W_FB, P_OUT, OVF, out_valid
    );

    modport slave (
        input  start, acc_len, in_valid, S, COUT, out_ready,
        output in_ready, W_FB, P_OUT, OVF, out_valid
    );
endinterface

// File: rtl/alu_p_accumulator.sv
// Accumulates acc_len ALU sums through the W feedback path and reports the final P with a sticky carry flag.
// Latency: result valid 1 cycle after the final accepted term; W_FB is combinational from stored P.
// Backpressure: terms accepted only in ACC; the result is held in DONE until out_ready.
module alu_p_accumulator #(
    parameter int Width = 48,
    parameter int LenW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_p_accumulator_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LenW-1:0] LenOne = {{(LenW-1){1'b0}}, 1'b1};
    localparam logic [LenW:0]   CntOne = {{LenW{1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [LenW-1:0]  len_q;
    logic [LenW:0]    cnt_q;
    logic [LenW:0]    cnt_inc;
    logic [Width-1:0] p_q;
    logic             ovf_sticky_q;
    logic [Width-1:0] p_out_q;
    logic             ovf_q;

    logic             in_ready;
    logic             out_valid;
    logic [Width-1:0] w_fb;
    logic             accept;
    logic             last_term;

    // cnt is one bit wider than len so cnt+1 never wraps, even at the maximum length.
    assign cnt_inc   = cnt_q + CntOne;
    assign accept    = bus.in_valid & in_ready;
    assign last_term = accept && (cnt_inc == {1'b0, len_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)     state_d = ACC;
            ACC:     if (last_term)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First term of a run must see W=0, so feedback is only live once a term has been taken.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_fb      = '0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (cnt_q != '0) begin
                    w_fb = p_q;
                end
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= '0;
            cnt_q        <= '0;
            p_q          <= '0;
            ovf_sticky_q <= 1'b0;
            p_out_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                len_q        <= (bus.acc_len == '0) ? LenOne : bus.acc_len;
                cnt_q        <= '0;
                p_q          <= '0;
                ovf_sticky_q <= 1'b0;
            end else if (accept) begin
                p_q          <= bus.S;
                ovf_sticky_q <= ovf_sticky_q | bus.COUT;
                cnt_q        <= cnt_inc;
            end
            // Result registers only change on the final term; they keep their value after hand-off.
            if (last_term) begin
                p_out_q <= bus.S;
                ovf_q   <= ovf_sticky_q | bus.COUT;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.W_FB      = w_fb;
    assign bus.P_OUT     = p_out_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_alu_p_accumulator.sv
// Directed bench for alu_p_accumulator: table of complete runs plus hand sequences for stalls,
// DONE hold, ignored start/in_valid and mid-run reset.
module tb_alu_p_accumulator;

    localparam int Width = 48;
    localparam int LenW  = 8;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    alu_p_accumulator_if #(.Width(Width), .LenW(LenW)) bus ();

    alu_p_accumulator #(.Width(Width), .LenW(LenW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]            len;
        int                    nterms;
        logic [3:0][Width-1:0] s;
        logic [3:0]            cout;
        logic [Width-1:0]      exp_p;
        logic                  exp_ovf;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [7:0] len, input int n,
                                input logic [Width-1:0] s0, input logic [Width-1:0] s1,
                                input logic [Width-1:0] s2, input logic [Width-1:0] s3,
                                input logic [3:0] c, input logic [Width-1:0] ep, input logic eo);
        vec_t v;
        v.len     = len;
        v.nterms  = n;
        v.s[0]    = s0;
        v.s[1]    = s1;
        v.s[2]    = s2;
        v.s[3]    = s3;
        v.cout    = c;
        v.exp_p   = ep;
        v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [Width-1:0] act, input logic [Width-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [Width-1:0] exp_w;
        bus.start   = 1'b1;
        bus.acc_len = v.len;
        step();
        bus.start   = 1'b0;
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        for (int t = 0; t < v.nterms; t++) begin
            bus.in_valid = 1'b1;
            bus.S        = v.s[t];
            bus.COUT     = v.cout[t];
            #1;
            exp_w = (t == 0) ? '0 : v.s[t-1];
            chk($sformatf("%s_wfb%0d", tag, t), bus.W_FB, exp_w);
            step();
        end
        bus.in_valid = 1'b0;
        bus.COUT     = 1'b0;
        chk1({tag, "_out_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_p_out"}, bus.P_OUT, v.exp_p);
        chk1({tag, "_ovf"}, bus.OVF, v.exp_ovf);
        chk1({tag, "_in_ready_done"}, bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk1({tag, "_out_valid_drop"}, bus.out_valid, 1'b0);
        chk({tag, "_p_out_kept"}, bus.P_OUT, v.exp_p);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = mk(8'd3, 3, 48'd10, 48'd20, 48'd30, 48'd0, 4'b0000, 48'd30, 1'b0);
        vecs[1] = mk(8'd0, 1, 48'h123, 48'd0, 48'd0, 48'd0, 4'b0000, 48'h123, 1'b0);
        vecs[2] = mk(8'd2, 2, 48'hF000_0000_0000, 48'h2000_0000_0000, 48'd0, 48'd0,
                     4'b0001, 48'h2000_0000_0000, 1'b1);
        vecs[3] = mk(8'd2, 2, 48'd3, 48'd4, 48'd0, 48'd0, 4'b0000, 48'd4, 1'b0);
        vecs[4] = mk(8'd1, 1, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 48'd0, 4'b0000,
                     48'hFFFF_FFFF_FFFF, 1'b0);
        vecs[5] = mk(8'd4, 4, 48'd1, 48'd3, 48'd6, 48'd10, 4'b1000, 48'd10, 1'b1);

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.acc_len   = '0;
        bus.in_valid  = 1'b0;
        bus.S         = '0;
        bus.COUT      = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_p_out", bus.P_OUT, '0);
        chk1("rst_ovf", bus.OVF, 1'b0);
        chk("rst_wfb", bus.W_FB, '0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Stalled input, then a long-held result with stray start/in_valid.
        bus.start   = 1'b1;
        bus.acc_len = 8'd2;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.S        = 48'd100;
        bus.COUT     = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.S        = 48'd555;
        bus.COUT     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gap_wfb%0d", k), bus.W_FB, 48'd100);
            chk1($sformatf("gap_out_valid%0d", k), bus.out_valid, 1'b0);
            step();
        end
        bus.in_valid = 1'b1;
        bus.S        = 48'd50;
        bus.COUT     = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.S        = 48'd999;
            bus.COUT     = 1'b1;
            bus.start    = 1'b1;
            bus.acc_len  = 8'd3;
            #1;
            chk1($sformatf("hold_out_valid%0d", k), bus.out_valid, 1'b1);
            chk1($sformatf("hold_in_ready%0d", k), bus.in_ready, 1'b0);
            chk($sformatf("hold_p_out%0d", k), bus.P_OUT, 48'd50);
            chk1($sformatf("hold_ovf%0d", k), bus.OVF, 1'b1);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        chk1("hs_out_valid", bus.out_valid, 1'b0);
        chk1("hs_in_ready", bus.in_ready, 1'b0);
        chk("hs_p_out", bus.P_OUT, 48'd50);
        step();
        chk1("hs_start_ignored", bus.in_ready, 1'b0);

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.S         = 48'd77;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk1("idle_out_valid", bus.out_valid, 1'b0);
        chk("idle_p_out", bus.P_OUT, 48'd50);
        chk1("idle_ovf", bus.OVF, 1'b1);

        // Reset in the middle of a four-term run.
        bus.start   = 1'b1;
        bus.acc_len = 8'd4;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.S        = 48'd5;
        bus.COUT     = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.COUT     = 1'b0;
        chk("mid_wfb", bus.W_FB, 48'd5);
        reset = 1'b1;
        #1;
        chk("arst_wfb", bus.W_FB, '0);
        chk("arst_p_out", bus.P_OUT, '0);
        chk1("arst_ovf", bus.OVF, 1'b0);
        chk1("arst_out_valid", bus.out_valid, 1'b0);
        chk1("arst_in_ready", bus.in_ready, 1'b0);
        step();
        reset = 1'b0;
        step();
        run_vec(mk(8'd1, 1, 48'd7, 48'd0, 48'd0, 48'd0, 4'b0000, 48'd7, 1'b0), "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
